// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer:
//   - seq_state_e      : 2-bit encoding of the release sequence states
//   - RST_CNT_MAX      : saturation value of the abort/re-entry counter
//   - sat_inc8()       : saturating 8-bit increment used for reset_count
// No ports (package).
// -----------------------------------------------------------------------------
package reset_seq_pkg;

    // Release sequence: hold everything, release core, release peripherals, run.
    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_CORE   = 2'd1,
        S_PERIPH = 2'd2,
        S_RUN    = 2'd3
    } seq_state_e;

    localparam logic [7:0] RST_CNT_MAX = 8'd255;

    // Increment that sticks at RST_CNT_MAX instead of wrapping to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == RST_CNT_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rst_sync_bit.sv
// -----------------------------------------------------------------------------
// rst_sync_bit
// Single-bit flop chain used to bring an asynchronous level into the
// axis_aclk domain. The chain is cleared/preset asynchronously to RESET_VAL
// so that, while the block is in reset, the synchronized value already sits
// at its "safe" level (request asserted / clock not locked).
//
// Parameters:
//   STAGES    : number of flops in the chain (>=1)
//   RESET_VAL : value loaded into every flop while i_rst_n is low
// Ports:
//   i_clk   in  1  sampling clock
//   i_rst_n in  1  asynchronous active-low clear/preset
//   i_d     in  1  raw asynchronous input
//   o_q     out 1  synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module rst_sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw input through the chain; preset/clear asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Top-of-design reset controller. Synchronizes the raw reset request and the
// clock-locked flag, requires HOLD_CYCLES consecutive qualifying cycles, and
// then releases the core reset, the peripheral reset and finally reset_done,
// STAGE_GAP cycles apart. Losing qualification in any released state aborts
// back to HOLD and drops every output on the same edge.
//
// Parameters:
//   SYNC_STAGES : depth of the request/lock synchronization path (>=2)
//   HOLD_CYCLES : qualifying cycles needed before core release (>=1)
//   STAGE_GAP   : cycles between core release, peripheral release, done (>=1)
//   CNT_WIDTH   : cycle counter width, must hold max(HOLD_CYCLES, STAGE_GAP)
// Ports:
//   axis_aclk     in  1  sole clock
//   axis_resetn   in  1  asynchronous active-low block reset
//   ext_reset_in  in  1  raw asynchronous reset request, active-high
//   clk_locked    in  1  raw asynchronous clock-locked flag, active-high
//   core_resetn   out 1  registered core-domain reset, active-low
//   periph_resetn out 1  registered peripheral-domain reset, active-low
//   reset_done    out 1  registered, high when fully out of reset
//   reset_count   out 8  aborts back into HOLD, saturating at 255
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_CYCLES = 200,
    parameter int STAGE_GAP   = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic       axis_aclk,
    input  logic       axis_resetn,
    input  logic       ext_reset_in,
    input  logic       clk_locked,
    output logic       core_resetn,
    output logic       periph_resetn,
    output logic       reset_done,
    output logic [7:0] reset_count
);

    // The FSM state/counter registers act as the final sampling stage of the
    // synchronization path, so the explicit chains are one flop shorter than
    // SYNC_STAGES. A change on a raw input just after edge k is acted on by
    // the FSM at edge k+SYNC_STAGES.
    localparam int SYNC_FLOPS = SYNC_STAGES - 1;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(STAGE_GAP - 1);

    logic w_ext_sync;
    logic w_lock_sync;
    logic w_qual;

    seq_state_e           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_core_resetn;
    logic                 r_periph_resetn;
    logic                 r_reset_done;
    logic [7:0]           r_reset_count;

    // Request synchronizer presets to "request asserted" so reset is held.
    rst_sync_bit #(
        .STAGES    (SYNC_FLOPS),
        .RESET_VAL (1'b1)
    ) u_sync_ext (
        .i_clk   (axis_aclk),
        .i_rst_n (axis_resetn),
        .i_d     (ext_reset_in),
        .o_q     (w_ext_sync)
    );

    // Lock synchronizer clears to "not locked" so reset is held.
    rst_sync_bit #(
        .STAGES    (SYNC_FLOPS),
        .RESET_VAL (1'b0)
    ) u_sync_lock (
        .i_clk   (axis_aclk),
        .i_rst_n (axis_resetn),
        .i_d     (clk_locked),
        .o_q     (w_lock_sync)
    );

    assign w_qual = !w_ext_sync && w_lock_sync;

    // Release sequencer: state, cycle counter, staged outputs and abort count.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state         <= S_HOLD;
            r_cnt           <= CNT_ZERO;
            r_core_resetn   <= 1'b0;
            r_periph_resetn <= 1'b0;
            r_reset_done    <= 1'b0;
            r_reset_count   <= 8'd0;
        end else if ((r_state != S_HOLD) && !w_qual) begin
            // Abort wins over any stage transition due in the same cycle.
            r_state         <= S_HOLD;
            r_cnt           <= CNT_ZERO;
            r_core_resetn   <= 1'b0;
            r_periph_resetn <= 1'b0;
            r_reset_done    <= 1'b0;
            r_reset_count   <= sat_inc8(r_reset_count);
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_periph_resetn <= 1'b0;
                    r_reset_done    <= 1'b0;
                    if (w_qual) begin
                        if (r_cnt == HOLD_LAST) begin
                            r_state       <= S_CORE;
                            r_cnt         <= CNT_ZERO;
                            r_core_resetn <= 1'b1;
                        end else begin
                            r_cnt         <= r_cnt + CNT_ONE;
                            r_core_resetn <= 1'b0;
                        end
                    end else begin
                        // Any gap in qualification restarts the full count.
                        r_cnt         <= CNT_ZERO;
                        r_core_resetn <= 1'b0;
                    end
                end
                S_CORE: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state         <= S_PERIPH;
                        r_cnt           <= CNT_ZERO;
                        r_periph_resetn <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_PERIPH: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state      <= S_RUN;
                        r_cnt        <= CNT_ZERO;
                        r_reset_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    // Unreachable encoding: fall back to the fully-held state.
                    r_state         <= S_HOLD;
                    r_cnt           <= CNT_ZERO;
                    r_core_resetn   <= 1'b0;
                    r_periph_resetn <= 1'b0;
                    r_reset_done    <= 1'b0;
                end
            endcase
        end
    end

    assign core_resetn   = r_core_resetn;
    assign periph_resetn = r_periph_resetn;
    assign reset_done    = r_reset_done;
    assign reset_count   = r_reset_count;

endmodule
